// File: rtl/mask_stage_pkg.sv
// mask_stage_pkg
// Shared types and helpers for the mask stage unit.
//   - default geometry (K_MAX/K_MIN/W/PACKET_LENGTH/MASK_DEPTH)
//   - packet_t / matrix_t / row_parity_t for the default geometry
//   - mask_aw(): address width of the mask bank, never below 1 bit
//   - clamp_k(): clamps the runtime column count into [k_min, k_max]
package mask_stage_pkg;

  localparam int K_MAX_DEF         = 128;
  localparam int K_MIN_DEF         = 2;
  localparam int W_DEF             = 4;
  localparam int PACKET_LENGTH_DEF = 2;
  localparam int MASK_DEPTH_DEF    = 4;

  typedef logic [PACKET_LENGTH_DEF-1:0]        packet_t;
  typedef packet_t [0:W_DEF-1][0:K_MAX_DEF-1]  matrix_t;
  typedef packet_t [0:W_DEF-1]                 row_parity_t;

  // A single mask set still needs a one-bit select port.
  function automatic int mask_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [31:0] clamp_k(input logic [31:0] k,
                                          input int k_min,
                                          input int k_max);
    if (k < 32'(k_min)) return 32'(k_min);
    if (k > 32'(k_max)) return 32'(k_max);
    return k;
  endfunction

endpackage

// File: rtl/mask_stage_unit_xor_tree.sv
// xor_reduce_tree
// Balanced XOR reduction of N packets of PW bits each (one matrix row).
// Ports:
//   data   in  [0:N-1][PW-1:0]  packets of one row
//   result out [PW-1:0]         XOR of all packets
// The input is zero-padded to the next power of two so every level of the
// tree halves the operand count.
module xor_reduce_tree #(
  parameter int N  = 128,
  parameter int PW = 2
) (
  input  logic [0:N-1][PW-1:0] data,
  output logic [PW-1:0]        result
);

  localparam int LEVELS = (N <= 1) ? 0 : $clog2(N);
  localparam int NP     = 1 << LEVELS;

  logic [0:NP-1][PW-1:0] leaf;
  logic [0:NP-1][PW-1:0] node;

  for (genvar gi = 0; gi < NP; gi++) begin : g_leaf
    if (gi < N) begin : g_data
      assign leaf[gi] = data[gi];
    end else begin : g_pad
      assign leaf[gi] = '0;
    end
  end

  // Pairwise reduction, level by level; each level folds 2*s entries into s.
  always_comb begin
    node = leaf;
    for (int s = NP / 2; s >= 1; s = s / 2) begin
      for (int i = 0; i < s; i++) begin
        node[i] = node[2*i] ^ node[2*i+1];
      end
    end
    result = node[0];
  end

endmodule

// File: rtl/mask_stage_unit.sv
// mask_stage_unit
// Two-stage valid/ready pipeline that masks a W x K_MAX packet matrix with a
// selectable stored mask set, zeroes columns at or beyond the runtime K and
// optionally emits a per-row XOR reduction.
// Optional feature macro: MASK_XOR_REDUCE_EN (builds the row parity trees;
// without it out_parity is tied to zero, timing unchanged).
// Ports:
//   clk, rst                      clock, async active-high reset
//   cfg_k                         active column count, sampled per accepted beat
//   mask_wr_en/addr/data          mask bank write port (visible next cycle)
//   in_valid/in_ready             input handshake
//   in_packets, in_mask_sel       input matrix and mask set index
//   out_valid/out_ready           output handshake
//   out_product, out_parity       masked matrix and per-row XOR
//   beat_cnt                      completed output transfers (wraps)
module mask_stage_unit
  import mask_stage_pkg::*;
#(
  parameter int K_MAX         = K_MAX_DEF,
  parameter int K_MIN         = K_MIN_DEF,
  parameter int W             = W_DEF,
  parameter int PACKET_LENGTH = PACKET_LENGTH_DEF,
  parameter int MASK_DEPTH    = MASK_DEPTH_DEF,
  localparam int MASK_AW      = mask_aw(MASK_DEPTH),
  localparam int KW           = $clog2(K_MAX + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [KW-1:0]                                 cfg_k,
  input  logic                                          mask_wr_en,
  input  logic [MASK_AW-1:0]                            mask_wr_addr,
  input  logic [0:W-1][0:K_MAX-1][PACKET_LENGTH-1:0]    mask_wr_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [0:W-1][0:K_MAX-1][PACKET_LENGTH-1:0]    in_packets,
  input  logic [MASK_AW-1:0]                            in_mask_sel,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [0:W-1][0:K_MAX-1][PACKET_LENGTH-1:0]    out_product,
  output logic [0:W-1][PACKET_LENGTH-1:0]               out_parity,
  output logic [31:0]                                   beat_cnt
);

  typedef logic [0:W-1][0:K_MAX-1][PACKET_LENGTH-1:0] mat_t;

  mat_t        bank_reg [0:MASK_DEPTH-1];
  mat_t        bank_rd;
  mat_t        masked;
  mat_t        s1_data_reg;
  mat_t        s2_data_reg;
  logic        s1_valid_reg;
  logic        s2_valid_reg;
  logic [31:0] beat_cnt_reg;
  logic [31:0] k_eff;
  logic        sel_ok;
  logic        s2_advance;

  assign s2_advance = !s2_valid_reg || out_ready;
  assign in_ready   = !s1_valid_reg || s2_advance;
  assign k_eff      = clamp_k(32'(cfg_k), K_MIN, K_MAX);
  assign sel_ok     = 32'(in_mask_sel) < MASK_DEPTH;

  // Out-of-range selects behave as an all-zero mask.
  always_comb begin
    bank_rd = '0;
    if (sel_ok) bank_rd = bank_reg[in_mask_sel];
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_row
    for (genvar gj = 0; gj < K_MAX; gj++) begin : g_col
      assign masked[gi][gj] = (32'(gj) < k_eff) ?
                              (in_packets[gi][gj] & bank_rd[gi][gj]) : '0;
    end
  end

  // Bank reads above use the current register contents, so a write in the
  // same cycle as a capture is seen only by later beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MASK_DEPTH; i++) bank_reg[i] <= '0;
    end else if (mask_wr_en && (32'(mask_wr_addr) < MASK_DEPTH)) begin
      bank_reg[mask_wr_addr] <= mask_wr_data;
    end
  end

  // Stage 1: masked capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) s1_data_reg <= masked;
    end
  end

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
    end else if (s2_advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) s2_data_reg <= s1_data_reg;
    end
  end

`ifdef MASK_XOR_REDUCE_EN
  logic [0:W-1][PACKET_LENGTH-1:0] parity_next;
  logic [0:W-1][PACKET_LENGTH-1:0] parity_reg;

  for (genvar gi = 0; gi < W; gi++) begin : g_par
    xor_reduce_tree #(
      .N  (K_MAX),
      .PW (PACKET_LENGTH)
    ) u_tree (
      .data   (s1_data_reg[gi]),
      .result (parity_next[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_reg <= '0;
    end else if (s2_advance && s1_valid_reg) begin
      parity_reg <= parity_next;
    end
  end

  assign out_parity = parity_reg;
`else
  assign out_parity = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_reg <= '0;
    end else if (s2_valid_reg && out_ready) begin
      beat_cnt_reg <= beat_cnt_reg + 32'd1;
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_product = s2_data_reg;
  assign beat_cnt    = beat_cnt_reg;

endmodule

// File: tb/tb_mask_stage_unit.sv
// tb_mask_stage_unit
// Directed bench for mask_stage_unit at W=2, K_MAX=4, PACKET_LENGTH=2,
// MASK_DEPTH=4. Expected matrices are hand-computed 16-bit constants
// (row 0 in the upper byte, column 0 in the upper two bits of each byte).
module tb_mask_stage_unit;

  localparam int W     = 2;
  localparam int K_MAX = 4;
  localparam int PL    = 2;
  localparam int MD    = 4;
  localparam int K_MIN = 2;

  typedef logic [0:W-1][0:K_MAX-1][PL-1:0] mat_t;
  typedef logic [0:W-1][PL-1:0]            par_t;

`ifdef MASK_XOR_REDUCE_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cfg_k;
  logic        mask_wr_en;
  logic [1:0]  mask_wr_addr;
  mat_t        mask_wr_data;
  logic        in_valid;
  logic        in_ready;
  mat_t        in_packets;
  logic [1:0]  in_mask_sel;
  logic        out_valid;
  logic        out_ready;
  mat_t        out_product;
  par_t        out_parity;
  logic [31:0] beat_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  mask_stage_unit #(
    .K_MAX         (K_MAX),
    .K_MIN         (K_MIN),
    .W             (W),
    .PACKET_LENGTH (PL),
    .MASK_DEPTH    (MD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_k        (cfg_k),
    .mask_wr_en   (mask_wr_en),
    .mask_wr_addr (mask_wr_addr),
    .mask_wr_data (mask_wr_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_packets   (in_packets),
    .in_mask_sel  (in_mask_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .out_parity   (out_parity),
    .beat_cnt     (beat_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_par(input par_t p);
    return XOR_EN ? 64'(p) : 64'd0;
  endfunction

  task automatic write_mask(input logic [1:0] addr, input mat_t d);
    mask_wr_en   = 1'b1;
    mask_wr_addr = addr;
    mask_wr_data = d;
    step();
    mask_wr_en   = 1'b0;
  endtask

  // One beat through an unstalled pipe: 2-cycle latency, then drain.
  task automatic beat(input string tag, input mat_t d, input logic [1:0] sel,
                      input logic [2:0] k, input mat_t ep, input par_t epar);
    in_packets  = d;
    in_mask_sel = sel;
    cfg_k       = k;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, ".lat1"}, 64'(out_valid), 64'd0);
    step();
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".prod"}, 64'(out_product), 64'(ep));
    check({tag, ".par"}, 64'(out_parity), exp_par(epar));
    step();
    exp_cnt++;
    check({tag, ".cnt"}, 64'(beat_cnt), 64'(exp_cnt));
  endtask

  initial begin
    cfg_k        = 3'd4;
    mask_wr_en   = 1'b0;
    mask_wr_addr = '0;
    mask_wr_data = '0;
    in_valid     = 1'b0;
    in_packets   = '0;
    in_mask_sel  = '0;
    out_ready    = 1'b1;
    exp_cnt      = '0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.product", 64'(out_product), 64'd0);
    check("rst.parity", 64'(out_parity), 64'd0);
    check("rst.beat_cnt", 64'(beat_cnt), 64'd0);
    step();
    check("rst.in_ready", 64'(in_ready), 64'd1);

    // Mask select
    write_mask(2'd1, 16'hFFFF);
    write_mask(2'd2, 16'h5555);
    beat("sel1", 16'hAAAA, 2'd1, 3'd4, 16'hAAAA, 4'b0000);
    beat("sel2", 16'hAAAA, 2'd2, 3'd4, 16'h0000, 4'b0000);
    // Mixed rows: row0 = 01,10,11,00 -> 00; row1 = 11,11,01,10 -> 11
    beat("mixed", 16'h6CF6, 2'd1, 3'd4, 16'h6CF6, 4'b0011);

    // K clamping
    beat("k3", 16'hFFFF, 2'd1, 3'd3, 16'hFCFC, 4'b1111);
    beat("k0", 16'hFFFF, 2'd1, 3'd0, 16'hF0F0, 4'b0000);
    beat("k7", 16'hFFFF, 2'd1, 3'd7, 16'hFFFF, 4'b0000);
    beat("k2", 16'hFFFF, 2'd1, 3'd2, 16'hF0F0, 4'b0000);

    // Backpressure: three beats against a stalled consumer
    out_ready   = 1'b0;
    in_mask_sel = 2'd1;
    cfg_k       = 3'd4;
    in_packets  = 16'h5555;
    in_valid    = 1'b1;
    step();
    check("bp.ready_after1", 64'(in_ready), 64'd1);
    in_packets = 16'hAAAA;
    step();
    check("bp.ready_after2", 64'(in_ready), 64'd0);
    check("bp.valid", 64'(out_valid), 64'd1);
    in_packets = 16'hFFFF;
    step();
    check("bp.hold1", 64'(out_product), 64'h5555);
    check("bp.ready_hold", 64'(in_ready), 64'd0);
    step();
    check("bp.hold2", 64'(out_product), 64'h5555);
    out_ready = 1'b1;
    #1;
    check("bp.ready_comb", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp.out2", 64'(out_product), 64'hAAAA);
    step();
    check("bp.out3", 64'(out_product), 64'hFFFF);
    check("bp.valid3", 64'(out_valid), 64'd1);
    step();
    exp_cnt = exp_cnt + 32'd3;
    check("bp.drained", 64'(out_valid), 64'd0);
    check("bp.cnt", 64'(beat_cnt), 64'(exp_cnt));

    // Write/read collision on mask set 0
    mask_wr_en   = 1'b1;
    mask_wr_addr = 2'd0;
    mask_wr_data = 16'hFFFF;
    in_packets   = 16'hFFFF;
    in_mask_sel  = 2'd0;
    cfg_k        = 3'd4;
    in_valid     = 1'b1;
    step();
    mask_wr_en = 1'b0;
    step();
    in_valid = 1'b0;
    check("coll.old", 64'(out_product), 64'h0000);
    step();
    check("coll.new", 64'(out_product), 64'hFFFF);
    step();
    exp_cnt = exp_cnt + 32'd2;
    check("coll.cnt", 64'(beat_cnt), 64'(exp_cnt));

    // Reset with both stages full
    out_ready   = 1'b0;
    in_packets  = 16'hFFFF;
    in_mask_sel = 2'd1;
    in_valid    = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check("mrst.full_valid", 64'(out_valid), 64'd1);
    check("mrst.full_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("mrst.valid", 64'(out_valid), 64'd0);
    check("mrst.cnt", 64'(beat_cnt), 64'd0);
    check("mrst.product", 64'(out_product), 64'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = '0;
    step();
    check("mrst.no_spurious", 64'(out_valid), 64'd0);
    beat("mrst.cleared", 16'hFFFF, 2'd1, 3'd4, 16'h0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mask_stage_unit.md
# mask_stage_unit

Pipelined, handshaked successor of the combinational mask unit for the EC engine. It holds a bank of selectable mask sets written through a load port. It applies a selected mask to each incoming W×K_MAX packet matrix and masks off columns beyond a runtime K. It emits the masked product and, optionally, a per-row GF(2) XOR reduction (parity contribution) to the downstream encoder stage.

## Interface
- K_MAX, 128: maximum data columns.
- K_MIN, 2: minimum legal runtime K.
- W, 4: rows (bit-planes) per matrix.
- PACKET_LENGTH, 2: bits per packet.
- MASK_DEPTH, 4: number of stored mask sets; MASK_AW = max(1,$clog2(MASK_DEPTH)).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_k  in  $clog2(K_MAX+1)  active column count, sampled per accepted beat.
- mask_wr_en  in  1  write mask set.
- mask_wr_addr  in  MASK_AW  mask set index.
- mask_wr_data  in  [PACKET_LENGTH-1:0] [0:W-1][0:K_MAX-1]  mask set contents.
- in_valid / in_ready  in / out  1  input handshake.
- in_packets  in  [PACKET_LENGTH-1:0] [0:W-1][0:K_MAX-1]  packet matrix.
- in_mask_sel  in  MASK_AW  mask set applied to this beat.
- out_valid / out_ready  out / in  1  output handshake.
- out_product  out  [PACKET_LENGTH-1:0] [0:W-1][0:K_MAX-1]  masked matrix.
- out_parity  out  [PACKET_LENGTH-1:0] [0:W-1]  per-row XOR of out_product over j (macro-gated).
- beat_cnt  out  32  count of completed output transfers.

## Operation
- Transfer occurs when valid && ready at either port.
- S1 capture on an input transfer: p[i][j] = in_packets[i][j] & bank[in_mask_sel][i][j] if j < k_eff, else 0.
- k_eff = cfg_k clamped to [K_MIN, K_MAX].
- in_mask_sel ≥ MASK_DEPTH is treated as an all-zero mask.
- S2 capture from S1: product copied; parity[i] = XOR over j of p[i][j], computed combinationally from S1 into S2.
- Two-stage valid/ready pipeline, no bubbles:
  - in_ready = !s1_valid || s2_advance, where s2_advance = !s2_valid || out_ready.
  - S2 holds its data unchanged while out_valid && !out_ready.
- Mask bank: registered. A write takes effect the cycle after mask_wr_en. A same-cycle input capture reading the same address sees the old contents.
- beat_cnt increments on each output transfer and wraps 2^32−1 → 0.

## Timing
- Latency: input transfer at cycle t → out_valid at t+2 if unstalled. Throughput 1 beat/cycle.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.
- Reset values: s1_valid = s2_valid = 0, out_valid = 0, out_product = 0, out_parity = 0, beat_cnt = 0, all mask sets = 0. in_ready is 1 from the first cycle after reset.
- Reset asserted mid-operation: in-flight beats are dropped, the bank is cleared, and the block must not produce a spurious out_valid on deassert.
- Simultaneous S2 drain and S1 fill in the same cycle: both complete, no data lost.
- cfg_k changed mid-stream affects only beats accepted after the change.

## Configuration
- MASK_XOR_REDUCE_EN defined: reduction logic built; out_parity is valid alongside out_product.
- Not defined: no reduction logic; out_parity is tied to 0. Latency and handshake are identical.

## Structure
- Package mask_stage_pkg:
  - typedefs for packet_t, matrix_t ([0:W-1][0:K_MAX-1] of packet_t) and row_parity_t;
  - function clamp_k;
  - localparam MASK_AW helper.
- Sub-module xor_reduce_tree: per-row balanced XOR tree, K_MAX inputs of PACKET_LENGTH bits. Instantiated W times under the macro.

## Test plan
Run with W=2, K_MAX=4, PACKET_LENGTH=2, MASK_DEPTH=4 and the macro defined.
- Mask select: write set 1 = all 2'b11, set 2 = all 2'b01. Input all 2'b10, cfg_k=4 with sel 1 → product all 2'b10, parity 2'b00. With sel 2 → product all 2'b00.
- cfg_k clamping: set 1, input all 2'b11. cfg_k=3 → column 3 reads 0, parity per row = 2'b11. cfg_k=0 → behaves as k=2, parity 2'b00. cfg_k=7 → behaves as k=4.
- Backpressure: hold out_ready=0 and send 3 beats. in_ready drops after 2 accepted, S2 data is stable. Release → 3 beats emerge in order, beat_cnt=3.
- Write/read collision: write set 0 = all 2'b11 while a beat with sel 0 is accepted in the same cycle → that beat's product is 0. The next beat is unmasked.
- Reset mid-stream: assert rst with both stages full → out_valid=0 immediately, beat_cnt=0. After release, a beat with sel 1 yields product 0 (bank cleared).
- Macro undefined build: repeat the first scenario → out_parity=0, product and 2-cycle latency unchanged.
